// File: rtl/dest_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// dest_hazard_ctrl
//
// Execute-stage hazard and forwarding controller. Selects the EX write
// destination (rd or rt), tracks that destination with its write/load
// attributes through MEM and WB, and from the tracked state derives the EX
// operand forwarding selects and the load-use stall / ID-EX bubble.
//
// Ports
//   clk, rst_n            pipeline clock (rising edge), async active-low reset
//   id_rs, id_rt          ID-stage source register numbers
//   id_uses_rs/_rt        ID instruction actually reads rs / rt
//   id_flush              ID instruction is being squashed
//   ex_valid              ID/EX holds a real instruction
//   ex_rs, ex_rt, ex_rd   EX-stage register fields
//   ex_reg_dst            1: destination rd, 0: destination rt
//   ex_reg_write          EX instruction writes the register file
//   ex_mem_read           EX instruction is a load
//   mem_busy              memory stage not ready; whole pipeline freezes
//   ex_dest               selected EX destination
//   fwd_a, fwd_b          2'b00 regfile, 2'b10 from EX/MEM, 2'b01 from MEM/WB
//   stall                 hold PC and IF/ID
//   ex_bubble             clear ID/EX on the next edge
//   stall_count           saturating count of load-use bubbles
//
// All control outputs are combinational in the same cycle and are forced to
// zero while rst_n is low.
// -----------------------------------------------------------------------------
module dest_hazard_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic             id_flush,
    input  logic             ex_valid,
    input  logic [4:0]       ex_rs,
    input  logic [4:0]       ex_rt,
    input  logic [4:0]       ex_rd,
    input  logic             ex_reg_dst,
    input  logic             ex_reg_write,
    input  logic             ex_mem_read,
    input  logic             mem_busy,
    output logic [4:0]       ex_dest,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             stall,
    output logic             ex_bubble,
    output logic [CNT_W-1:0] stall_count
);

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] FWD_WB  = 2'b01;

    // Forwarding select for one operand. The MEM stage is the newest value and
    // wins over WB. A load sitting in MEM has no data yet, so it never
    // forwards from EX/MEM; the load-use bubble guarantees the consumer sees
    // it from WB instead. Register 0 never matches because the write flags
    // are already cleared for destination 0.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] src,
        input logic [4:0] m_dest,
        input logic       m_w,
        input logic       m_load,
        input logic [4:0] w_dest,
        input logic       w_w
    );
        logic [1:0] sel;
        if (m_w && (m_dest == src) && !m_load) begin
            sel = FWD_MEM;
        end else if (w_w && (w_dest == src)) begin
            sel = FWD_WB;
        end else begin
            sel = FWD_RF;
        end
        return sel;
    endfunction

    // Tracker state
    logic [4:0]       mem_dest_r;
    logic             mem_w_r;
    logic             mem_load_r;
    logic [4:0]       wb_dest_r;
    logic             wb_w_r;
    logic [CNT_W-1:0] stall_count_r;

    // Combinational results
    logic [4:0] dest_sel_s;
    logic       ex_w_s;
    logic       ex_load_s;
    logic       luh_s;
    logic [4:0] ex_dest_s;
    logic [1:0] fwd_a_s;
    logic [1:0] fwd_b_s;
    logic       stall_s;
    logic       ex_bubble_s;

    // Destination select, effective write, load-use detect and output gating
    always_comb begin
        dest_sel_s  = ex_reg_dst ? ex_rd : ex_rt;
        ex_w_s      = ex_valid & ex_reg_write & (dest_sel_s != 5'd0);
        ex_load_s   = ex_w_s & ex_mem_read;
        luh_s       = ex_load_s &
                      ((id_uses_rs & (id_rs == dest_sel_s)) |
                       (id_uses_rt & (id_rt == dest_sel_s)));
        ex_dest_s   = 5'd0;
        fwd_a_s     = FWD_RF;
        fwd_b_s     = FWD_RF;
        stall_s     = 1'b0;
        ex_bubble_s = 1'b0;
        if (rst_n) begin
            ex_dest_s   = dest_sel_s;
            fwd_a_s     = fwd_sel(ex_rs, mem_dest_r, mem_w_r, mem_load_r,
                                  wb_dest_r, wb_w_r);
            fwd_b_s     = fwd_sel(ex_rt, mem_dest_r, mem_w_r, mem_load_r,
                                  wb_dest_r, wb_w_r);
            // A squashed consumer needs no stall; a frozen memory stage
            // stalls everything but must not inject a bubble, so the
            // pipeline resumes intact.
            stall_s     = (luh_s & ~id_flush) | mem_busy;
            ex_bubble_s = luh_s & ~id_flush & ~mem_busy;
        end else begin
            ex_dest_s   = 5'd0;
        end
    end

    // EX->MEM->WB destination tracker; the EX slot is captured as-is on a
    // load-use stall because the bubble only goes into ID/EX
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_dest_r <= 5'd0;
            mem_w_r    <= 1'b0;
            mem_load_r <= 1'b0;
            wb_dest_r  <= 5'd0;
            wb_w_r     <= 1'b0;
        end else if (!mem_busy) begin
            mem_dest_r <= dest_sel_s;
            mem_w_r    <= ex_w_s;
            mem_load_r <= ex_load_s;
            wb_dest_r  <= mem_dest_r;
            wb_w_r     <= mem_w_r;
        end else begin
            mem_dest_r <= mem_dest_r;
            mem_w_r    <= mem_w_r;
            mem_load_r <= mem_load_r;
            wb_dest_r  <= wb_dest_r;
            wb_w_r     <= wb_w_r;
        end
    end

    // Saturating load-use bubble counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_count_r <= {CNT_W{1'b0}};
        end else if (ex_bubble_s && (stall_count_r != {CNT_W{1'b1}})) begin
            stall_count_r <= stall_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            stall_count_r <= stall_count_r;
        end
    end

    assign ex_dest     = ex_dest_s;
    assign fwd_a       = fwd_a_s;
    assign fwd_b       = fwd_b_s;
    assign stall       = stall_s;
    assign ex_bubble   = ex_bubble_s;
    assign stall_count = stall_count_r;

endmodule

// File: tb/tb_dest_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dest_hazard_ctrl
//
// Directed bench for dest_hazard_ctrl. A reference model keeps the list of
// instructions that have left EX (newest first, trimmed to MEM and WB) and a
// bubble tally; a negedge compare process checks every output against it each
// cycle. Directed steps additionally pin hand-computed literal values.
// -----------------------------------------------------------------------------
module tb_dest_hazard_ctrl;

    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [4:0]       id_rs, id_rt;
    logic             id_uses_rs, id_uses_rt, id_flush;
    logic             ex_valid;
    logic [4:0]       ex_rs, ex_rt, ex_rd;
    logic             ex_reg_dst, ex_reg_write, ex_mem_read, mem_busy;
    logic [4:0]       ex_dest;
    logic [1:0]       fwd_a, fwd_b;
    logic             stall, ex_bubble;
    logic [CNT_W-1:0] stall_count;

    dest_hazard_ctrl #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_flush(id_flush),
        .ex_valid(ex_valid), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
        .ex_reg_dst(ex_reg_dst), .ex_reg_write(ex_reg_write),
        .ex_mem_read(ex_mem_read), .mem_busy(mem_busy),
        .ex_dest(ex_dest), .fwd_a(fwd_a), .fwd_b(fwd_b),
        .stall(stall), .ex_bubble(ex_bubble), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [4:0] dest;
        logic       w;
        logic       load;
    } ent_t;

    ent_t q[$];          // q[0] = instruction now in MEM, q[1] = in WB
    int   mcnt = 0;

    function automatic logic [4:0] m_dest();
        return ex_reg_dst ? ex_rd : ex_rt;
    endfunction

    function automatic logic m_w();
        return ex_valid && ex_reg_write && (m_dest() != 5'd0);
    endfunction

    function automatic logic m_luh();
        return m_w() && ex_mem_read &&
               ((id_uses_rs && id_rs == m_dest()) || (id_uses_rt && id_rt == m_dest()));
    endfunction

    function automatic logic [1:0] m_fwd(input logic [4:0] x);
        if (q.size() >= 1 && q[0].w && q[0].dest == x && !q[0].load) return 2'b10;
        if (q.size() >= 2 && q[1].w && q[1].dest == x) return 2'b01;
        return 2'b00;
    endfunction

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                q.delete();
                mcnt = 0;
            end else if (!mem_busy) begin
                if (m_luh() && !id_flush && mcnt < (1 << CNT_W) - 1) mcnt++;
                q.push_front('{dest: m_dest(), w: m_w(), load: m_w() && ex_mem_read});
                if (q.size() > 2) void'(q.pop_back());
            end
        end
    end

    // Every-cycle comparison against the model
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                check("rst ex_dest", ex_dest, 32'd0);
                check("rst fwd_a", fwd_a, 32'd0);
                check("rst fwd_b", fwd_b, 32'd0);
                check("rst stall", stall, 32'd0);
                check("rst ex_bubble", ex_bubble, 32'd0);
            end else begin
                check("ex_dest", ex_dest, m_dest());
                check("fwd_a", fwd_a, m_fwd(ex_rs));
                check("fwd_b", fwd_b, m_fwd(ex_rt));
                check("stall", stall, (m_luh() && !id_flush) || mem_busy);
                check("ex_bubble", ex_bubble, m_luh() && !id_flush && !mem_busy);
            end
            check("stall_count", stall_count, mcnt);
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic ex_set(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                          input logic [4:0] rd, input logic dst, input logic rw,
                          input logic mr);
        ex_valid = v; ex_rs = rs; ex_rt = rt; ex_rd = rd;
        ex_reg_dst = dst; ex_reg_write = rw; ex_mem_read = mr;
    endtask

    task automatic id_set(input logic [4:0] rs, input logic [4:0] rt,
                          input logic ur, input logic ut, input logic fl);
        id_rs = rs; id_rt = rt; id_uses_rs = ur; id_uses_rt = ut; id_flush = fl;
    endtask

    initial begin
        rst_n = 1'b0;
        mem_busy = 1'b0;
        id_set(5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        ex_set(1'b1, 5'd0, 5'd0, 5'd8, 1'b1, 1'b1, 1'b0);
        #12;
        check("reset ex_dest forced", ex_dest, 32'd0);
        check("reset stall_count", stall_count, 32'd0);
        rst_n = 1'b1;

        // R-type: add r8, consumer one and two cycles later
        step(); ex_set(1'b1, 5'd1, 5'd2, 5'd8, 1'b1, 1'b1, 1'b0);
        #1 check("rtype ex_dest", ex_dest, 32'd8);
        step(); ex_set(1'b1, 5'd8, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
        #1 check("rtype fwd_a mem", fwd_a, 32'h2);
        step();
        #1 check("rtype fwd_a wb", fwd_a, 32'h1);

        // I-type: dest is rt=9, rd=3 must not forward
        step(); ex_set(1'b1, 5'd0, 5'd9, 5'd3, 1'b0, 1'b1, 1'b0);
        #1 check("itype ex_dest", ex_dest, 32'd9);
        step(); ex_set(1'b1, 5'd3, 5'd9, 5'd0, 1'b1, 1'b0, 1'b0);
        #1 check("itype fwd_b", fwd_b, 32'h2);
        check("itype no fwd r3", fwd_a, 32'h0);

        // MEM and WB both write r10: MEM wins
        step(); ex_set(1'b1, 5'd0, 5'd0, 5'd10, 1'b1, 1'b1, 1'b0);
        step(); ex_set(1'b1, 5'd1, 5'd1, 5'd10, 1'b1, 1'b1, 1'b0);
        step(); ex_set(1'b1, 5'd10, 5'd10, 5'd0, 1'b1, 1'b0, 1'b0);
        #1 check("dual fwd_a", fwd_a, 32'h2);
        check("dual fwd_b", fwd_b, 32'h2);
        step();
        #1 check("dual fwd_a wb", fwd_a, 32'h1);

        // Load-use: lw r5 in EX, ID reads rs=5
        step(); ex_set(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        step();
        step(); ex_set(1'b1, 5'd0, 5'd5, 5'd0, 1'b0, 1'b1, 1'b1);
        id_set(5'd5, 5'd0, 1'b1, 1'b0, 1'b0);
        #1 check("lu stall", stall, 32'd1);
        check("lu bubble", ex_bubble, 32'd1);
        check("lu count before", stall_count, 32'd0);
        step(); ex_set(1'b0, 5'd5, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        #1 check("lu stall cleared", stall, 32'd0);
        check("lu count after", stall_count, 32'd1);
        check("lu load in mem no fwd", fwd_a, 32'h0);
        step(); ex_set(1'b1, 5'd5, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
        id_set(5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        #1 check("lu consumer fwd_a", fwd_a, 32'h1);
        check("lu consumer no stall", stall, 32'd0);

        // Flush overrides load-use; then rt-side load-use
        step(); ex_set(1'b1, 5'd0, 5'd5, 5'd0, 1'b0, 1'b1, 1'b1);
        id_set(5'd5, 5'd0, 1'b1, 1'b0, 1'b1);
        #1 check("flush stall", stall, 32'd0);
        check("flush bubble", ex_bubble, 32'd0);
        id_set(5'd0, 5'd5, 1'b0, 1'b1, 1'b0);
        #1 check("rt lu stall", stall, 32'd1);
        step(); id_set(5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        #1 check("rt lu count", stall_count, 32'd2);

        // Writer to r0 never forwards
        ex_set(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0);
        #1 check("zero ex_dest", ex_dest, 32'd0);
        step(); ex_set(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
        #1 check("zero fwd_a", fwd_a, 32'h0);

        // mem_busy freeze with r7 pending in MEM and a load-use in EX/ID
        step(); ex_set(1'b1, 5'd0, 5'd0, 5'd7, 1'b1, 1'b1, 1'b0);
        step(); ex_set(1'b1, 5'd7, 5'd6, 5'd6, 1'b0, 1'b1, 1'b1);
        id_set(5'd6, 5'd0, 1'b1, 1'b0, 1'b0);
        mem_busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1 check("busy stall", stall, 32'd1);
            check("busy bubble", ex_bubble, 32'd0);
            check("busy fwd r7", fwd_a, 32'h2);
            check("busy count", stall_count, 32'd2);
            step();
        end
        mem_busy = 1'b0;
        #1 check("unbusy fwd r7", fwd_a, 32'h2);
        check("unbusy bubble", ex_bubble, 32'd1);
        step();
        #1 check("unbusy count", stall_count, 32'd3);

        // Async reset in the middle of a load-use stall
        check("pre-reset stall", stall, 32'd1);
        rst_n = 1'b0;
        #1 check("async stall", stall, 32'd0);
        check("async bubble", ex_bubble, 32'd0);
        check("async fwd_a", fwd_a, 32'h0);
        check("async ex_dest", ex_dest, 32'd0);
        check("async count", stall_count, 32'd0);
        rst_n = 1'b1;

        // Saturation: continuous load-use bubbles
        for (int i = 0; i < 65535; i++) begin
            step();
            if (i == 65533) check("sat count FFFE", stall_count, 32'hFFFE);
        end
        check("sat count FFFF", stall_count, 32'hFFFF);
        step();
        step();
        check("sat hold", stall_count, 32'hFFFF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
